// File: rtl/scan_pkg.sv
// Shared types and defaults for the serial pattern scan controller.
//   state_t    : controller FSM states (IDLE, SHIFT, REPORT)
//   DEF_*      : default parameter values
//   clamp_len(): maps a raw pattern-length request onto 1..max_len
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    REPORT
  } state_t;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_PAT_MAX = 4;
  localparam int unsigned DEF_CNT_W   = 4;

  // A zero length would match every bit and lengths beyond the history
  // cannot be compared, so both ends are pulled into range.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    if (len == 0)            return 1;
    else if (len > max_len)  return max_len;
    else                     return len;
  endfunction

endpackage

// File: rtl/pattern_bit_detector.sv
// Mealy bit-pattern detector fed one bit per step.
//   clk, rst : clock, synchronous active-high reset
//   din      : current serial bit
//   step     : din is valid this cycle; history advances on the edge
//   clr      : clear history and seen-counter (new configuration)
//   pat_q    : pattern, bit [len_q-1] oldest, bit 0 newest
//   len_q    : pattern length, 1..PAT_MAX
//   hit      : combinational match of {history, din} against the pattern
// Build option SCAN_NO_OVERLAP_EN: a hit also clears history and seen, so
// consecutive matches never share bits.
module pattern_bit_detector
  import scan_pkg::*;
#(
  parameter int unsigned PAT_MAX = DEF_PAT_MAX
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din,
  input  logic                         step,
  input  logic                         clr,
  input  logic [PAT_MAX-1:0]           pat_q,
  input  logic [$clog2(PAT_MAX+1)-1:0] len_q,
  output logic                         hit
);

  localparam int unsigned LEN_W = $clog2(PAT_MAX + 1);
  localparam logic [LEN_W-1:0] SEEN_MAX = LEN_W'(PAT_MAX);

  logic [PAT_MAX-2:0] hist, hist_d;
  logic [LEN_W-1:0]   seen, seen_d;
  logic [PAT_MAX-1:0] window, mask;
  logic [LEN_W:0]     seen_p1;

  always_comb begin
    window  = {hist, din};
    seen_p1 = {1'b0, seen} + (LEN_W + 1)'(1);
    mask    = '0;
    for (int unsigned i = 0; i < PAT_MAX; i++) begin
      mask[i] = (i < 32'(len_q));
    end
    hit = step && (seen_p1 >= {1'b0, len_q}) &&
          ((window & mask) == (pat_q & mask));
  end

  always_comb begin
    hist_d = hist;
    seen_d = seen;
    if (clr) begin
      hist_d = '0;
      seen_d = '0;
    end else if (step) begin
      hist_d = window[PAT_MAX-2:0];
      if (seen != SEEN_MAX) seen_d = seen + LEN_W'(1);
`ifdef SCAN_NO_OVERLAP_EN
      if (hit) begin
        hist_d = '0;
        seen_d = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '0;
      seen <= '0;
    end else begin
      hist <= hist_d;
      seen <= seen_d;
    end
  end

endmodule

// File: rtl/serial_pattern_scan_ctrl.sv
// Serialises parallel words MSB first into a pattern detector, counts the
// hits per word and reports a summary over a valid/ready handshake.
//   clk, rst           : clock, synchronous active-high reset
//   cfg_we/pat/len     : configuration write (honoured only in IDLE)
//   in_valid/ready/data: word input handshake
//   out_valid/ready    : summary handshake
//   out_hits           : hits in the word (saturating)
//   out_first          : bit index of the first hit, 0 = MSB
//   out_any            : at least one hit
//   busy               : controller not in IDLE
// Build option SCAN_NO_OVERLAP_EN (in pattern_bit_detector): non-overlapping
// match counting.
module serial_pattern_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned PAT_MAX = DEF_PAT_MAX,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [PAT_MAX-1:0]           cfg_pat,
  input  logic [$clog2(PAT_MAX+1)-1:0] cfg_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CNT_W-1:0]             out_hits,
  output logic [$clog2(DATA_W)-1:0]    out_first,
  output logic                         out_any,
  output logic                         busy
);

  localparam int unsigned LEN_W = $clog2(PAT_MAX + 1);
  localparam int unsigned IDX_W = $clog2(DATA_W);

  state_t              state, state_d;
  logic [PAT_MAX-1:0]  pat_q;
  logic [LEN_W-1:0]    len_q;
  logic [DATA_W-1:0]   data_q;
  logic [IDX_W-1:0]    idx;
  logic [CNT_W-1:0]    hits_q;
  logic [IDX_W-1:0]    first_q;
  logic                cfg_take, accept, step, hit;

  assign cfg_take = cfg_we && (state == IDLE);
  assign accept   = in_valid && (state == IDLE);
  assign step     = (state == SHIFT);

  // Config is registered on the accepting edge, so a same-cycle write
  // already governs the first SHIFT step of that word.
  pattern_bit_detector #(.PAT_MAX(PAT_MAX)) u_det (
    .clk   (clk),
    .rst   (rst),
    .din   (data_q[DATA_W-1]),
    .step  (step),
    .clr   (cfg_take),
    .pat_q (pat_q),
    .len_q (len_q),
    .hit   (hit)
  );

  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (idx == IDX_W'(DATA_W - 1)) state_d = REPORT;
      end
      REPORT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pat_q   <= '0;
      len_q   <= LEN_W'(PAT_MAX);
      data_q  <= '0;
      idx     <= '0;
      hits_q  <= '0;
      first_q <= '0;
    end else begin
      state <= state_d;
      if (cfg_take) begin
        pat_q <= cfg_pat;
        len_q <= LEN_W'(clamp_len(32'(cfg_len), PAT_MAX));
      end
      if (accept) begin
        data_q  <= in_data;
        idx     <= '0;
        hits_q  <= '0;
        first_q <= '0;
      end else if (step) begin
        // Word is shifted left so the bit under test is always the MSB.
        data_q <= {data_q[DATA_W-2:0], 1'b0};
        idx    <= idx + IDX_W'(1);
        if (hit) begin
          if (hits_q == '0) first_q <= idx;
          if (hits_q != '1) hits_q  <= hits_q + CNT_W'(1);
        end
      end
    end
  end

  assign out_hits  = hits_q;
  assign out_first = first_q;
  assign out_any   = (hits_q != '0);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_serial_pattern_scan_ctrl.sv
module tb_serial_pattern_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [3:0] cfg_pat;
  logic [2:0] cfg_len;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_hits;
  logic [2:0] out_first;
  logic       out_any;
  logic       busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state: pattern, effective length, and the serial bits
  // seen since the last clear (newest at the back).
  logic [3:0]  m_pat;
  int unsigned m_len;
  bit          m_bits[$];

  int unsigned last_hits, last_first;

  serial_pattern_scan_ctrl #(.DATA_W(8), .PAT_MAX(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat),
    .cfg_len(cfg_len), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_hits(out_hits), .out_first(out_first), .out_any(out_any),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_cfg(input logic [3:0] pat, input int unsigned len);
    m_pat = pat;
    m_len = (len == 0) ? 1 : (len > 4) ? 4 : len;
    m_bits.delete();
  endfunction

  function automatic void model_scan(input logic [7:0] w,
                                     output int unsigned h,
                                     output int unsigned f);
    bit match;
    h = 0;
    f = 0;
    for (int i = 0; i < 8; i++) begin
      m_bits.push_back(w[7-i]);
      if (m_bits.size() > 4) void'(m_bits.pop_front());
      if (m_bits.size() >= m_len) begin
        match = 1'b1;
        for (int j = 0; j < int'(m_len); j++)
          if (m_bits[m_bits.size()-1-j] != m_pat[j]) match = 1'b0;
        if (match) begin
          if (h == 0) f = i;
          if (h < 15) h++;
`ifdef SCAN_NO_OVERLAP_EN
          m_bits.delete();
`endif
        end
      end
    end
  endfunction

  task automatic do_cfg(input logic [3:0] pat, input logic [2:0] len);
    cfg_we = 1'b1; cfg_pat = pat; cfg_len = len;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    model_cfg(pat, len);
  endtask

  // Drives one word from IDLE through REPORT and the output handshake.
  task automatic run_word(input logic [7:0] w, input int stall,
                          input bit with_cfg, input logic [3:0] cp,
                          input logic [2:0] cl, input bit mid_cfg);
    int unsigned eh, ef;
    int cycles;
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_data = w;
    if (with_cfg) begin
      cfg_we = 1'b1; cfg_pat = cp; cfg_len = cl;
      model_cfg(cp, cl);
    end
    model_scan(w, eh, ef);
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0; in_data = $urandom;
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      cfg_we = (mid_cfg && cycles == 3);
      if (cfg_we) begin
        cfg_pat = ~m_pat; cfg_len = 3'($urandom_range(0, 7));
      end
      @(posedge clk); #1;
      cycles++;
    end
    cfg_we = 1'b0;
    check("latency", cycles, 8);
    if (!out_valid) return;
    last_hits  = out_hits;
    last_first = out_first;
    check("hits", out_hits, eh);
    check("first", out_first, ef);
    check("any", out_any, eh != 0);
    check("in_ready_rep", in_ready, 0);
    check("busy_rep", busy, 1);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_valid", out_valid, 1);
      check("stall_hits", out_hits, eh);
      check("stall_first", out_first, ef);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  initial begin
    int stall;
    bit wc, mc;
    rst = 1'b1; cfg_we = 1'b0; cfg_pat = '0; cfg_len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_cfg(4'b0000, 4);
    check("rst_valid", out_valid, 0);
    check("rst_hits", out_hits, 0);
    check("rst_first", out_first, 0);
    check("rst_any", out_any, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_len", dut.len_q, 4);

    do_cfg(4'b1011, 3'd4);
    run_word(8'b1011_0110, 0, 0, 0, 0, 0);
`ifdef SCAN_NO_OVERLAP_EN
    check("tp1_hits", last_hits, 1);
`else
    check("tp1_hits", last_hits, 2);
`endif
    check("tp1_first", last_first, 3);

    do_cfg(4'b0011, 3'd2);
    run_word(8'hFF, 5, 0, 0, 0, 0);
`ifndef SCAN_NO_OVERLAP_EN
    check("tp_ff_hits", last_hits, 7);
    check("tp_ff_first", last_first, 1);
`endif
    run_word(8'h80, 0, 0, 0, 0, 1);
`ifndef SCAN_NO_OVERLAP_EN
    check("tp_80_hits", last_hits, 1);
    check("tp_80_first", last_first, 0);
`endif

    do_cfg(4'b0101, 3'd3);
    run_word(8'h00, 1, 0, 0, 0, 0);
    check("tp_00_hits", last_hits, 0);

    do_cfg(4'b0001, 3'd0);
    run_word(8'hA5, 0, 0, 0, 0, 0);
    check("tp_a5_hits", last_hits, 4);
    check("tp_a5_first", last_first, 0);

    // Reset while a word is being shifted.
    in_valid = 1'b1; in_data = 8'h5A;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_cfg(4'b0000, 4);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_hits", out_hits, 0);
    check("mid_rst_len", dut.len_q, 4);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 5) == 0)
        do_cfg(4'($urandom), 3'($urandom_range(0, 7)));
      stall = $urandom_range(0, 3);
      wc = ($urandom_range(0, 2) == 0);
      mc = ($urandom_range(0, 3) == 0);
      run_word(8'($urandom), stall, wc, 4'($urandom),
               3'($urandom_range(0, 7)), mc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
